cmp_nibble_seq: RTL and testbench

Sequential magnitude comparator/subtractor for WIDTH-bit operands.
- Computes A−B one nibble per cycle through a single 4-bit adder datapath, chaining the borrow (carry) between cycles in a register.
- Reports gt/eq/lt in unsigned or signed (two's complement) mode, plus the full difference.
- Sits between the operand registers and the comparator display/decision logic, so wide compares need only one 4-bit adder.

---
 rtl/cmp_nibble_seq_pkg.sv | 18 +
 rtl/cmp_nibble_seq_add_4_bits.sv | 27 ++
 rtl/cmp_nibble_seq.sv | 121 ++++++++++++
 tb/tb_cmp_nibble_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cmp_nibble_seq_pkg.sv
// ----------------------------------------------------------------------------
// cmp_nibble_seq_pkg : shared state encoding and nibble width  |  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cmp_nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cmp_nibble_seq_add_4_bits.sv
// ----------------------------------------------------------------------------
// add_4_bits : 4-bit ripple-carry adder with carry in/out  |  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module add_4_bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

`default_nettype wire

// File: rtl/cmp_nibble_seq.sv
// ----------------------------------------------------------------------------
// cmp_nibble_seq : nibble-serial A-B comparator (unsigned/signed)  |  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_nibble_seq
    import cmp_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [WIDTH-1:0] diff
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               zacc;
    logic               smode;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s;
    logic               c4;
    logic               last;
    logic               accept;
    logic               eq_nxt;
    logic               lt_nxt;
    logic               ovf;

    assign a_nib  = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib  = ~b_q[idx*NIBBLE_W +: NIBBLE_W];
    assign last   = (idx == IDX_W'(NIB - 1));
    assign accept = start && (state == IDLE || state == DONE);

    add_4_bits u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s),
        .cout (c4)
    );

    // Flags only matter on the final nibble, where s/c4 carry the MSB information
    assign eq_nxt = zacc & (s == '0);
    assign ovf    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ s[NIBBLE_W-1]);
    assign lt_nxt = smode ? (s[NIBBLE_W-1] ^ ovf) : ~c4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            zacc  <= 1'b0;
            smode <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            diff  <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= 1'b1;
            zacc  <= 1'b1;
            smode <= signed_mode;
            a_q   <= a;
            b_q   <= b;
        end else if (state == RUN) begin
            diff[idx*NIBBLE_W +: NIBBLE_W] <= s;
            carry <= c4;
            zacc  <= eq_nxt;
            idx   <= idx + 1'b1;
            if (last) begin
                eq <= eq_nxt;
                lt <= lt_nxt;
                gt <= ~lt_nxt & ~eq_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmp_nibble_seq.sv
// ----------------------------------------------------------------------------
// tb_cmp_nibble_seq : directed self-checking bench for cmp_nibble_seq  |  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmp_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, gt16, eq16, lt16;
    logic [15:0] diff16;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, gt8, eq8, lt8;
    logic [7:0]  diff8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .gt(gt16), .eq(eq16), .lt(lt16), .diff(diff16)
    );

    cmp_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .gt(gt8), .eq(eq8), .lt(lt8), .diff(diff8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one compare on the selected instance; flags are {gt,eq,lt}
    task automatic do_cmp(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                          input logic sm, input logic [15:0] ediff, input logic [2:0] eflags,
                          input int elat, input string tag);
        int n;
        @(negedge clk);
        if (w8) begin a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1; end
        else    begin a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        n = 0;
        while (!(w8 ? done8 : done16) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_flags"}, w8 ? {gt8, eq8, lt8} : {gt16, eq16, lt16}, eflags);
        chk({tag, "_diff"}, w8 ? {8'h00, diff8} : diff16, ediff);
        chk({tag, "_busy"}, w8 ? busy8 : busy16, 1'b0);
    endtask

    initial begin
        int seen_done;
        #12;
        chk("rst_flags", {busy16, done16, gt16, eq16, lt16}, 5'b0);
        chk("rst_diff", diff16, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        // Busy check during a compare, then the equal case
        @(negedge clk); a16 = 16'h1234; b16 = 16'h1234; sm16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        chk("t1_busy", {busy16, done16}, 2'b10);
        repeat (3) begin @(posedge clk); #1; end
        chk("t1_busy_last", busy16, 1'b1);
        @(posedge clk); #1;
        chk("t1_done", {busy16, done16}, 2'b01);
        chk("t1_flags", {gt16, eq16, lt16}, 3'b010);
        chk("t1_diff", diff16, 16'h0000);
        @(posedge clk); #1;
        chk("t1_done_pulse", done16, 1'b0);
        chk("t1_hold", {gt16, eq16, lt16}, 3'b010);

        do_cmp(0, 16'h0001, 16'hFFFF, 0, 16'h0002, 3'b001, 4, "t2u");
        do_cmp(0, 16'h0001, 16'hFFFF, 1, 16'h0002, 3'b100, 4, "t2s");
        do_cmp(0, 16'h8000, 16'h7FFF, 1, 16'h0001, 3'b001, 4, "t3s");
        do_cmp(0, 16'h8000, 16'h7FFF, 0, 16'h0001, 3'b100, 4, "t3u");

        // start held through RUN with junk operands; re-launch from DONE
        @(negedge clk); a16 = 16'h0005; b16 = 16'h0003; sm16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a16 = 16'h0001; b16 = 16'h0009; sm16 = 1'b1;
            @(posedge clk); #1;
        end
        chk("t4_done1", done16, 1'b1);
        chk("t4_flags1", {gt16, eq16, lt16}, 3'b100);
        chk("t4_diff1", diff16, 16'h0002);
        @(negedge clk); a16 = 16'h0010; b16 = 16'h0010; sm16 = 1'b0;
        @(posedge clk); #1; start16 = 1'b0;
        chk("t4_restart", {busy16, done16}, 2'b10);
        begin
            int n = 0;
            while (!done16 && n < 20) begin @(posedge clk); #1; n++; end
            chk("t4_lat2", n, 4);
        end
        chk("t4_flags2", {gt16, eq16, lt16}, 3'b010);
        chk("t4_diff2", diff16, 16'h0000);

        // Reset during nibble 2
        @(negedge clk); a16 = 16'h0F0F; b16 = 16'h0101; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out", {busy16, done16, gt16, eq16, lt16}, 5'b0);
        chk("t5_rst_diff", diff16, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        repeat (6) begin @(posedge clk); #1; if (done16 || busy16) seen_done = 1; end
        chk("t5_no_done", seen_done, 0);
        do_cmp(0, 16'h00FF, 16'h0100, 0, 16'hFFFF, 3'b001, 4, "t5");

        do_cmp(1, 16'h007F, 16'h0080, 1, 16'h00FF, 3'b100, 2, "t6s");
        do_cmp(1, 16'h007F, 16'h0080, 0, 16'h00FF, 3'b001, 2, "t6u");
        do_cmp(1, 16'h0042, 16'h0042, 1, 16'h0000, 3'b010, 2, "t6eq");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
